adc_scan_scheduler: RTL

ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

---
 rtl/adc_scan_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adc_scan_scheduler.sv
// Round-robin scan scheduler for a 4-channel muxed parallel ADC (CONVST/BUSY/CS/RD).
// Optional BUSY watchdog enabled by defining ADC_TIMEOUT_EN.
module adc_scan_scheduler #(
  parameter int SETTLE_CYC  = 4,
  parameter int RD_CYC      = 3,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] req,
  input  logic [2:0] pace,
  input  logic       BUSY,
  input  logic [7:0] D,
  output logic [1:0] chSel,
  output logic       CONVST,
  output logic       CS,
  output logic       RD,
  output logic [3:0] ack,
  output logic [7:0] dout,
  output logic [1:0] dch,
  output logic       dvalid,
  input  logic       dready,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, SETUP, CONV, WAITB, READ, GAP} state_t;

  state_t      state, state_nxt;
  logic [10:0] cnt, cnt_nxt;
  logic [10:0] gap_ld;
  logic [1:0]  last, cand, gnt_idx;
  logic        gnt_any, grant, capture;
`ifdef ADC_TIMEOUT_EN
  logic        tmo;
`endif

  // GAP plus the IDLE grant cycle spans 16<<pace cycles; 16<<7 wraps to 0 in 11 bits,
  // so the subtraction still yields 2046 for the largest pace.
  assign gap_ld = (11'd16 << pace) - 11'd2;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = last;
    cand    = last;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    capture   = 1'b0;
`ifdef ADC_TIMEOUT_EN
    tmo       = 1'b0;
`endif
    case (state)
      IDLE: if (gnt_any && (!dvalid || dready)) begin
        grant     = 1'b1;
        state_nxt = SETUP;
        cnt_nxt   = 11'(SETTLE_CYC - 1);
      end
      SETUP: if (cnt == '0) begin
        state_nxt = CONV;
        cnt_nxt   = 11'd1;
      end else cnt_nxt = cnt - 11'd1;
      CONV: if (cnt == '0) begin
        state_nxt = WAITB;
        cnt_nxt   = '0;
      end else cnt_nxt = cnt - 11'd1;
      WAITB: begin
        if (cnt >= 11'd2 && !BUSY) begin
          state_nxt = READ;
          cnt_nxt   = 11'(RD_CYC - 1);
        end
`ifdef ADC_TIMEOUT_EN
        else if (cnt == 11'(TIMEOUT_CYC - 1)) begin
          tmo       = 1'b1;
          state_nxt = GAP;
          cnt_nxt   = gap_ld;
        end
`endif
        else if (cnt != 11'h7FF) cnt_nxt = cnt + 11'd1;
      end
      READ: if (cnt == '0) begin
        capture   = 1'b1;
        state_nxt = GAP;
        cnt_nxt   = gap_ld;
      end else cnt_nxt = cnt - 11'd1;
      GAP: if (cnt == '0) state_nxt = IDLE;
           else cnt_nxt = cnt - 11'd1;
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Strobes are decoded from the next state so they align exactly with the state they belong to.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      last   <= 2'd3;
      ack    <= '0;
      chSel  <= '0;
      CONVST <= 1'b1;
      CS     <= 1'b1;
      RD     <= 1'b1;
      dout   <= '0;
      dch    <= '0;
      dvalid <= 1'b0;
    end else begin
      ack    <= grant ? (4'b0001 << gnt_idx) : 4'b0000;
      if (grant) begin
        chSel <= gnt_idx;
        last  <= gnt_idx;
      end
      CONVST <= (state_nxt != CONV);
      CS     <= (state_nxt != READ);
      RD     <= (state_nxt != READ);
      if (capture) begin
        dout   <= D;
        dch    <= chSel;
        dvalid <= 1'b1;
      end else if (dready) begin
        dvalid <= 1'b0;
      end
    end
  end

`ifdef ADC_TIMEOUT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) err <= 1'b0;
    else if (tmo) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
